// File: rtl/load_store_unit.sv
// Data-memory access sequencer: byte strobes, lane-shifted stores, extended loads,
// and misaligned accesses either split into two aligned beats or trapped.
module load_store_unit #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_wstrb,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [XLEN-1:0]       mem_rdata
);
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned SIDXW = $clog2(XLEN);

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StDone} state_e;
  state_e state_q, state_d;

  logic                  we_q, sign_q, split_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q, lo_q, hi_q;

  // Request decode, only meaningful in the acceptance cycle.
  logic       accept, req_illegal, req_misal, req_split, req_err;
  logic [3:0] req_n;
  logic [2:0] req_nmask;

  assign accept      = req_valid && req_ready;
  assign req_n       = 4'd1 << req_size;
  assign req_nmask   = 3'(req_n - 4'd1);
  assign req_illegal = (req_size == 2'd3) && (BYTES < 8);
  assign req_misal   = |(req_addr[2:0] & req_nmask);
  assign req_split   = (32'(req_addr[OFFW-1:0]) + 32'(req_n)) > BYTES;
  assign req_err     = req_illegal || (req_misal && !SPLIT_MISALIGNED);

  logic [OFFW-1:0]       off;
  logic [3:0]            n;
  logic [BYTES-1:0]      nmask;
  logic [2*BYTES-1:0]    strb_wide;
  logic [2*XLEN-1:0]     wdata_wide;
  logic [XLEN-1:0]       rd_shift, load_data;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [SIDXW-1:0]      sidx;
  logic                  sbit;

  assign off        = addr_q[OFFW-1:0];
  assign n          = 4'd1 << size_q;
  assign strb_wide  = {{BYTES{1'b0}}, nmask} << off;
  assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
  assign rd_shift   = XLEN'({hi_q, lo_q} >> {off, 3'b000});
  assign base_addr  = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  assign sidx       = SIDXW'((8 << size_q) - 1);
  assign sbit       = sign_q & rd_shift[sidx];

  always_comb begin
    nmask     = '0;
    load_data = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      nmask[i]          = (i < int'(n));
      load_data[8*i+:8] = (i < int'(n)) ? rd_shift[8*i+:8] : {8{sbit}};
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wstrb     = '0;
    mem_wdata     = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? StDone : StReq0;
      end
      StReq0: begin
        mem_req_valid = 1'b1;
        mem_we        = we_q;
        mem_addr      = base_addr;
        mem_wstrb     = strb_wide[BYTES-1:0];
        mem_wdata     = wdata_wide[XLEN-1:0];
        if (mem_req_ready) state_d = StWait0;
      end
      StWait0: if (mem_resp_valid) state_d = split_q ? StReq1 : StDone;
      StReq1: begin
        mem_req_valid = 1'b1;
        mem_we        = we_q;
        mem_addr      = base_addr + ADDR_WIDTH'(BYTES);
        mem_wstrb     = strb_wide[2*BYTES-1:BYTES];
        mem_wdata     = wdata_wide[2*XLEN-1:XLEN];
        if (mem_req_ready) state_d = StWait1;
      end
      StWait1: if (mem_resp_valid) state_d = StDone;
      StDone: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : load_data;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        split_q <= req_split;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        // hi stays zero for single-beat loads so the merge needs no special case
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state_q == StWait0 && mem_resp_valid) lo_q <= mem_rdata;
      if (state_q == StWait1 && mem_resp_valid) hi_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized loads/stores against a
// byte-level memory model, a 64-bit trapping instance, and mid-transaction reset.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        resp_valid, resp_err;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        w_req_valid, w_req_ready, w_req_we, w_req_sign;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr, w_mem_addr;
  logic [63:0] w_req_wdata, w_resp_rdata, w_mem_wdata, w_mem_rdata;
  logic        w_resp_valid, w_resp_err;
  logic        w_mem_req_valid, w_mem_req_ready, w_mem_we, w_mem_resp_valid;
  logic [7:0]  w_mem_wstrb;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_w (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_we(w_req_we), .req_size(w_req_size), .req_sign(w_req_sign), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata),
    .resp_err(w_resp_err), .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wstrb(w_mem_wstrb),
    .mem_wdata(w_mem_wdata), .mem_resp_valid(w_mem_resp_valid), .mem_rdata(w_mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory image: every aligned word B reads as rd_base ^ (B * rd_mul).
  logic [31:0] rd_base, rd_mul;
  function automatic logic [31:0] memw(input logic [31:0] b);
    return rd_base ^ (b * rd_mul);
  endfunction

  // Load result assembled byte by byte from the addressed memory bytes.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input bit sign);
    int nb = 1 << size;
    logic [31:0] r = '0;
    logic [31:0] a, w;
    for (int k = 0; k < nb; k++) begin
      a = addr + k;
      w = memw({a[31:2], 2'b00});
      r[8*k+:8] = w[8*a[1:0]+:8];
    end
    if (sign && r[8*nb-1]) for (int k = nb; k < 4; k++) r[8*k+:8] = 8'hFF;
    return r;
  endfunction

  // Beat b covers byte addresses base..base+3; lane j carries store byte (base+j-addr).
  task automatic model_beat(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input int b, output logic [31:0] baddr,
                            output logic [3:0] strb, output logic [31:0] wd);
    logic [31:0] rel;
    int nb = 1 << size;
    baddr = {addr[31:2], 2'b00} + 32'(4 * b);
    strb  = '0;
    wd    = '0;
    for (int j = 0; j < 4; j++) begin
      rel = baddr + j - addr;
      if (rel < 32'(nb)) strb[j] = 1'b1;
      if (rel < 32'd4) wd[8*j+:8] = wdata[8*rel[1:0]+:8];
    end
  endtask

  task automatic run_txn(input string nm, input bit we, input logic [1:0] size, input bit sign,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         input logic [31:0] exp_rdata, input bit exp_err);
    int nb = 1 << size;
    int beats_exp, beat = 0, c = 0, stall_left = stall;
    bit pending = 0, done = 0;
    logic [31:0] ba, pend_addr, wd;
    logic [3:0]  st;
    if (size == 2'd3) beats_exp = 0;
    else beats_exp = (int'(addr[1:0]) + nb > 4) ? 2 : 1;
    @(negedge clk);
    chk({nm, " req_ready idle"}, req_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_valid = 0; req_we = ~we; req_sign = ~sign; req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      mem_resp_valid = 0;
      if (pending) begin
        mem_resp_valid = 1; mem_rdata = memw(pend_addr); pending = 0;
      end
      mem_req_ready = 0;
      if (resp_valid) begin
        chk({nm, " latency"}, c, (beats_exp == 0) ? 1 : 1 + 2 * beats_exp + stall);
        chk({nm, " beats"}, beat, beats_exp);
        chk({nm, " resp_err"}, resp_err, exp_err);
        chk({nm, " resp_rdata"}, resp_rdata, exp_rdata);
        done = 1;
      end else if (mem_req_valid) begin
        chk({nm, " beat within count"}, beat < beats_exp, 1);
        model_beat(addr, size, wdata, beat, ba, st, wd);
        chk({nm, " mem_addr"}, mem_addr, ba);
        chk({nm, " mem_wstrb"}, mem_wstrb, st);
        chk({nm, " mem_wdata"}, mem_wdata, wd);
        chk({nm, " mem_we"}, mem_we, we);
        if (stall_left > 0) begin
          // a stray completion while the beat is still unaccepted must be ignored
          stall_left--; mem_resp_valid = 1; mem_rdata = 32'hBAD0BAD0;
        end else begin
          mem_req_ready = 1; pending = 1; pend_addr = ba; beat++;
        end
      end
    end
    if (!done) chk({nm, " timeout waiting for resp_valid"}, 0, 1);
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 0;
    chk({nm, " resp_valid single pulse"}, resp_valid, 0);
  endtask

  task automatic wide_txn(input string nm, input bit we, input logic [1:0] size, input bit sign,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input bit exp_err,
                          input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
    int c = 0;
    bit done = 0, pending = 0;
    @(negedge clk);
    w_req_valid = 1; w_req_we = we; w_req_size = size; w_req_sign = sign;
    w_req_addr = addr; w_req_wdata = wdata;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
      w_req_valid = 0;
      w_mem_resp_valid = pending; w_mem_rdata = rdata; pending = 0;
      w_mem_req_ready = 0;
      if (w_resp_valid) begin
        chk({nm, " latency"}, c, exp_err ? 1 : 3);
        chk({nm, " resp_err"}, w_resp_err, exp_err);
        chk({nm, " resp_rdata"}, w_resp_rdata, exp_rdata);
        done = 1;
      end else if (w_mem_req_valid) begin
        chk({nm, " unexpected memory beat"}, exp_err, 0);
        chk({nm, " mem_addr"}, w_mem_addr, exp_addr);
        chk({nm, " mem_wstrb"}, w_mem_wstrb, exp_strb);
        chk({nm, " mem_wdata"}, w_mem_wdata, exp_wdata);
        chk({nm, " mem_we"}, w_mem_we, we);
        w_mem_req_ready = 1; pending = 1;
      end
    end
    if (!done) chk({nm, " timeout waiting for resp_valid"}, 0, 1);
    @(negedge clk);
    w_mem_req_ready = 0; w_mem_resp_valid = 0;
    chk({nm, " resp_valid single pulse"}, w_resp_valid, 0);
  endtask

  task automatic reset_mid(input string nm, input bit in_wait);
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_sign = 0; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 0;
    chk({nm, " mem_req_valid before reset"}, mem_req_valid, 1);
    if (in_wait) begin
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
    end
    rst = 1;
    #1;
    chk({nm, " mem_req_valid on reset"}, mem_req_valid, 0);
    chk({nm, " req_ready on reset"}, req_ready, 1);
    @(negedge clk);
    rst = 0; mem_resp_valid = 1; mem_rdata = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp_valid = 0;
      chk({nm, " no resp after abort"}, resp_valid, 0);
      chk({nm, " no beat after abort"}, mem_req_valid, 0);
    end
  endtask

  typedef struct {
    string       nm;
    bit          we;
    logic [1:0]  size;
    bit          sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stall;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"lw aligned",       0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[1] = '{"lb sign",          0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 0};
    vecs[2] = '{"lhu zero",         0, 2'd1, 0, 32'h102, 32'h0, 32'h80112233, 0, 32'h00008011, 0};
    vecs[3] = '{"sw split",         1, 2'd2, 0, 32'h206, 32'hAABBCCDD, 32'h0, 0, 32'h0, 0};
    vecs[4] = '{"lw stall5",        0, 2'd2, 0, 32'h200, 32'h0, 32'h12345678, 5, 32'h12345678, 0};
    vecs[5] = '{"lw wrap",          0, 2'd2, 0, 32'hFFFFFFFE, 32'h0, 32'h11223344, 0,
                32'h33441122, 0};
    vecs[6] = '{"size3 illegal",    0, 2'd3, 0, 32'h10, 32'h0, 32'h55555555, 0, 32'h0, 1};
    vecs[7] = '{"lh misal in-word", 0, 2'd1, 1, 32'h101, 32'h0, 32'h80112233, 0, 32'h00001122, 0};
    vecs[8] = '{"lh split sign",    0, 2'd1, 1, 32'h103, 32'h0, 32'h80112233, 0, 32'h00003380, 0};
    vecs[9] = '{"sb lane3",         1, 2'd0, 0, 32'h207, 32'h12345655, 32'h0, 0, 32'h0, 0};

    rst = 1;
    req_valid = 0; req_we = 0; req_size = 0; req_sign = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    w_req_valid = 0; w_req_we = 0; w_req_size = 0; w_req_sign = 0; w_req_addr = 0;
    w_req_wdata = 0; w_mem_req_ready = 0; w_mem_resp_valid = 0; w_mem_rdata = 0;
    rd_base = 0; rd_mul = 0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_err", resp_err, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wstrb", mem_wstrb, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    rst = 0;

    foreach (vecs[i]) begin
      rd_base = vecs[i].rd; rd_mul = 0;
      run_txn(vecs[i].nm, vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr,
              vecs[i].wdata, vecs[i].stall, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    for (int i = 0; i < 200; i++) begin
      bit          we, sign;
      logic [1:0]  size;
      logic [31:0] addr, wdata, exp;
      we = 1'($urandom); sign = 1'($urandom); size = 2'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      wdata = $urandom; rd_base = $urandom; rd_mul = $urandom | 32'h1;
      exp = (we || size == 2'd3) ? 32'h0 : model_load(addr, size, sign);
      run_txn("random", we, size, sign, addr, wdata, $urandom_range(0, 2), exp, size == 2'd3);
    end

    wide_txn("trap lh misal", 0, 2'd1, 0, 32'h301, 64'h0, 64'h0, 1, 32'h0, 8'h0, 64'h0, 64'h0);
    wide_txn("x64 sd", 1, 2'd3, 0, 32'h8, 64'h1122334455667788, 64'h0, 0, 32'h8, 8'hFF,
             64'h1122334455667788, 64'h0);
    wide_txn("x64 lw upper", 0, 2'd2, 1, 32'h4, 64'h0, 64'h8877665544332211, 0, 32'h0, 8'hF0,
             64'h0, 64'hFFFFFFFF88776655);

    reset_mid("reset in wait0", 1);
    reset_mid("reset in req0", 0);
    rd_base = 32'hCAFEF00D; rd_mul = 0;
    run_txn("lw after reset", 0, 2'd2, 0, 32'h80, 32'h0, 0, 32'hCAFEF00D, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
